// File: rtl/ret_addr_stack_if.sv
// ret_addr_stack_if
// Bundles the return-address stack control inputs and status outputs.
//   master : execute/decode control side (drives stall/push/pop/clr_flags)
//   slave  : the stack itself (drives top_addr/empty/full/count/flags)
// Signals:
//   stall, push, pop, clr_flags, push_addr[WIDTH]  -> stack
//   top_addr[WIDTH], empty, full, count[$clog2(DEPTH)+1],
//   overflow, underflow                             <- stack
// When RAS_CHECKPOINT_EN is defined, ckpt_save / ckpt_restore are added
// for branch-mispredict recovery.
interface ret_addr_stack_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             stall;
  logic             push;
  logic [WIDTH-1:0] push_addr;
  logic             pop;
  logic             clr_flags;
  logic [WIDTH-1:0] top_addr;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
`ifdef RAS_CHECKPOINT_EN
  logic             ckpt_save;
  logic             ckpt_restore;

  modport master (
    output stall, push, push_addr, pop, clr_flags, ckpt_save, ckpt_restore,
    input  top_addr, empty, full, count, overflow, underflow
  );
  modport slave (
    input  stall, push, push_addr, pop, clr_flags, ckpt_save, ckpt_restore,
    output top_addr, empty, full, count, overflow, underflow
  );
`else
  modport master (
    output stall, push, push_addr, pop, clr_flags,
    input  top_addr, empty, full, count, overflow, underflow
  );
  modport slave (
    input  stall, push, push_addr, pop, clr_flags,
    output top_addr, empty, full, count, overflow, underflow
  );
`endif
endinterface

// File: rtl/ret_addr_stack.sv
// ret_addr_stack
// Hardware return-address stack for call/ret in the execute stage.
// Circular storage of DEPTH entries: pushing while full overwrites the
// oldest entry. Sticky overflow/underflow flags, stall holds all state.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   ras  : ret_addr_stack_if.slave (control inputs, top/status outputs)
// Optional feature macro: RAS_CHECKPOINT_EN (adds {tp,count} checkpoint
// save/restore via ras.ckpt_save / ras.ckpt_restore).
module ret_addr_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input logic             clk,
  input logic             rst,
  ret_addr_stack_if.slave ras
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0]    tp_q, tp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             we;
  logic [PW-1:0]    waddr;
  logic             do_push, do_pop;

`ifdef RAS_CHECKPOINT_EN
  logic [PW-1:0]    sh_tp_q, sh_tp_d;
  logic [CW-1:0]    sh_count_q, sh_count_d;
`endif

  // A restore overrides push/pop entirely (no write, no flag side effects).
  always_comb begin
    do_push = ras.push & ~ras.stall;
    do_pop  = ras.pop  & ~ras.stall;
`ifdef RAS_CHECKPOINT_EN
    do_push = do_push & ~ras.ckpt_restore;
    do_pop  = do_pop  & ~ras.ckpt_restore;
`endif
  end

  always_comb begin
    tp_d    = tp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    we      = 1'b0;
    waddr   = tp_q;
    if (!ras.stall && ras.clr_flags) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (do_push && do_pop) begin
      if (count_q != '0) begin
        // Replace the top in place; no pointer move, no flags even when full.
        we = 1'b1;
      end else begin
        unf_d   = 1'b1;
        tp_d    = tp_q + PW'(1);
        waddr   = tp_q + PW'(1);
        we      = 1'b1;
        count_d = CW'(1);
      end
    end else if (do_push) begin
      tp_d  = tp_q + PW'(1);
      waddr = tp_q + PW'(1);
      we    = 1'b1;
      if (count_q == FULL_CNT) ovf_d = 1'b1;
      else                     count_d = count_q + CW'(1);
    end else if (do_pop) begin
      if (count_q == '0) begin
        unf_d = 1'b1;
      end else begin
        tp_d    = tp_q - PW'(1);
        count_d = count_q - CW'(1);
      end
    end
`ifdef RAS_CHECKPOINT_EN
    sh_tp_d    = sh_tp_q;
    sh_count_d = sh_count_q;
    if (ras.ckpt_restore) begin
      tp_d    = sh_tp_q;
      count_d = sh_count_q;
    end else if (ras.ckpt_save && !ras.stall) begin
      sh_tp_d    = tp_q;
      sh_count_d = count_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
`ifdef RAS_CHECKPOINT_EN
      sh_tp_q    <= '0;
      sh_count_q <= '0;
`endif
    end else begin
      tp_q    <= tp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
`ifdef RAS_CHECKPOINT_EN
      sh_tp_q    <= sh_tp_d;
      sh_count_q <= sh_count_d;
`endif
    end
  end

  // Storage is not reset; count==0 masks its contents on top_addr.
  always_ff @(posedge clk) begin
    if (we && !rst) mem_q[waddr] <= ras.push_addr;
  end

  assign ras.top_addr  = (count_q == '0) ? '0 : mem_q[tp_q];
  assign ras.empty     = (count_q == '0);
  assign ras.full      = (count_q == FULL_CNT);
  assign ras.count     = count_q;
  assign ras.overflow  = ovf_q;
  assign ras.underflow = unf_q;
endmodule
